// File: rtl/spi_slave_responder.sv
// SPI responder for the 8-bit master: oversampled sclk/mosi/ss, rx byte strobe, tx reply byte.
// Optional sticky overrun detection is built when SPI_SLAVE_OVERRUN_EN is defined.
module spi_slave_responder #(
    parameter logic [7:0] DEFAULT_TX  = 8'h00,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    input  logic       ss,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       rx_overrun
);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic                   sclk_hist_q, ss_hist_q;
    logic                   sclk_s, mosi_s, ss_s;
    logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;

    state_t     state_q, state_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       miso_q, miso_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic       reload_q, reload_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       hold_take;
    logic [7:0] tx_src;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss};
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist_q;
    assign sclk_fall = ~sclk_s & sclk_hist_q;
    assign ss_rise   = ss_s & ~ss_hist_q;
    assign ss_fall   = ~ss_s & ss_hist_q;

    always_comb begin
        state_d    = state_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        bit_cnt_d  = bit_cnt_q;
        miso_d     = miso_q;
        reload_d   = reload_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        hold_take  = 1'b0;
        tx_src     = tx_shift_q;
        case (state_q)
            IDLE: begin
                miso_d    = 1'b0;
                bit_cnt_d = 3'd0;
                reload_d  = 1'b0;
                if (ss_fall) begin
                    state_d    = SHIFT;
                    tx_shift_d = hold_full_q ? hold_q : DEFAULT_TX;
                    hold_take  = hold_full_q;
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    // The byte-boundary reload is taken at the first rise of the next byte,
                    // so a reply loaded in response to rx_valid still goes out in this window.
                    if (reload_q) begin
                        tx_src    = hold_full_q ? hold_q : DEFAULT_TX;
                        hold_take = hold_full_q;
                        reload_d  = 1'b0;
                    end
                    miso_d     = tx_src[7];
                    tx_shift_d = {tx_src[6:0], 1'b0};
                end
                if (sclk_fall) begin
                    rx_shift_d = {rx_shift_q[6:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d  = rx_shift_d;
                        rx_valid_d = 1'b1;
                        reload_d   = 1'b1;
                    end
                end
                // ss rise wins over everything except a byte completing in the same cycle
                if (ss_rise) begin
                    state_d   = IDLE;
                    bit_cnt_d = 3'd0;
                    miso_d    = 1'b0;
                    reload_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q & ~hold_take;
        if (tx_load && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '1;
            sclk_hist_q <= 1'b0;
            ss_hist_q   <= 1'b1;
            state_q     <= IDLE;
            tx_shift_q  <= 8'h00;
            rx_shift_q  <= 8'h00;
            bit_cnt_q   <= 3'd0;
            miso_q      <= 1'b0;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            reload_q    <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            ss_sync_q   <= ss_sync_d;
            sclk_hist_q <= sclk_s;
            ss_hist_q   <= ss_s;
            state_q     <= state_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            bit_cnt_q   <= bit_cnt_d;
            miso_q      <= miso_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            reload_q    <= reload_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic ack_pend_q, ack_pend_d;
    logic rx_overrun_q, rx_overrun_d;

    // A tx_load between two completed bytes acknowledges the earlier one.
    always_comb begin
        ack_pend_d   = ack_pend_q;
        rx_overrun_d = rx_overrun_q;
        if (rx_valid_d) begin
            if (ack_pend_q && !tx_load)
                rx_overrun_d = 1'b1;
            ack_pend_d = 1'b1;
        end else if (tx_load) begin
            ack_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_pend_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            ack_pend_q   <= ack_pend_d;
            rx_overrun_q <= rx_overrun_d;
        end
    end

    assign rx_overrun = rx_overrun_q;
`else
    assign rx_overrun = 1'b0;
`endif

    assign miso     = miso_q;
    assign tx_ready = ~hold_full_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = (state_q == SHIFT);

endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: bit-banged master, rx scoreboard queue, frame table plus corner sequences.
module tb_spi_slave_responder;
    localparam int HALF = 8;

    logic       clk = 1'b0, reset = 1'b1;
    logic       sclk = 1'b0, mosi = 1'b0, ss = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       miso, tx_ready, rx_valid, busy, rx_overrun;
    logic [7:0] rx_data;

    int checks = 0, errors = 0;
    int rx_cnt = 0;
    logic prev_vld = 1'b0;
    logic [7:0] rx_exp_q[$];

    spi_slave_responder dut (
        .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .miso(miso), .ss(ss),
        .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .busy(busy), .rx_overrun(rx_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rx_valid) begin
            chk("rx_valid single cycle", {31'd0, prev_vld}, 32'd0);
            if (rx_exp_q.size() == 0)
                chk("rx_valid unexpected", 32'd1, 32'd0);
            else
                chk("rx_data", {24'd0, rx_data}, {24'd0, rx_exp_q.pop_front()});
            rx_cnt <= rx_cnt + 1;
        end
        prev_vld <= rx_valid;
    end

    task automatic load(input logic [7:0] b, input logic exp_ready_after);
        @(posedge clk); #1 tx_data = b; tx_load = 1'b1;
        @(posedge clk); #1 tx_load = 1'b0;
        chk("tx_ready after load", {31'd0, tx_ready}, {31'd0, exp_ready_after});
    endtask

    task automatic ss_low();
        @(posedge clk); #1 ss = 1'b0;
        for (int i = 0; i < 50 && !busy; i++) @(posedge clk);
        #1 chk("busy at ss fall", {31'd0, busy}, 32'd1);
        chk("tx_ready at ss fall", {31'd0, tx_ready}, 32'd1);
        repeat (HALF) @(posedge clk);
    endtask

    task automatic ss_high();
        repeat (HALF) @(posedge clk);
        #1 ss = 1'b1;
        repeat (HALF) @(posedge clk);
        #1 chk("busy after ss rise", {31'd0, busy}, 32'd0);
    endtask

    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            @(posedge clk); #1 mosi = mo[i]; sclk = 1'b1;
            repeat (HALF) @(posedge clk);
            #1 sclk = 1'b0; mi = {mi[6:0], miso};
            repeat (HALF) @(posedge clk);
        end
    endtask

    task automatic wait_rx(input int target, input string nm);
        for (int i = 0; i < 100 && rx_cnt < target; i++) @(posedge clk);
        #1 chk(nm, rx_cnt, target);
    endtask

    task automatic frame(input logic [7:0] mo, input logic [7:0] exp_mi, input string nm);
        logic [7:0] mi;
        int n;
        n = rx_cnt;
        ss_low();
        rx_exp_q.push_back(mo);
        xfer(mo, 8, mi);
        chk({nm, " miso byte"}, {24'd0, mi}, {24'd0, exp_mi});
        ss_high();
        wait_rx(n + 1, {nm, " rx count"});
    endtask

    typedef struct {
        logic       do_load;
        logic [7:0] load_b;
        logic [7:0] mosi_b;
        logic [7:0] exp_miso;
    } vec_t;
    vec_t vecs[5];

    initial begin
        logic [7:0] mi;
        int n;
        vecs[0] = '{1'b0, 8'h00, 8'hA5, 8'h00};
        vecs[1] = '{1'b1, 8'h3C, 8'h11, 8'h3C};
        vecs[2] = '{1'b0, 8'h00, 8'h5A, 8'h00};
        vecs[3] = '{1'b1, 8'hFF, 8'h00, 8'hFF};
        vecs[4] = '{1'b1, 8'h81, 8'h7E, 8'h81};

        repeat (3) @(posedge clk);
        #1 chk("reset miso", {31'd0, miso}, 32'd0);
        chk("reset tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("reset rx_data", {24'd0, rx_data}, 32'd0);
        chk("reset rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset rx_overrun", {31'd0, rx_overrun}, 32'd0);
        reset = 1'b0;
        repeat (3) @(posedge clk);

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].do_load) load(vecs[v].load_b, 1'b0);
            frame(vecs[v].mosi_b, vecs[v].exp_miso, $sformatf("vec%0d", v));
            chk("tx_ready after frame", {31'd0, tx_ready}, 32'd1);
        end
`ifdef SPI_SLAVE_OVERRUN_EN
        chk("rx_overrun after unacked bytes", {31'd0, rx_overrun}, 32'd1);
`else
        chk("rx_overrun tied low", {31'd0, rx_overrun}, 32'd0);
`endif

        // two bytes in one window; second reply loaded after the first rx_valid
        load(8'h55, 1'b0);
        n = rx_cnt;
        ss_low();
        rx_exp_q.push_back(8'h01);
        xfer(8'h01, 8, mi);
        chk("b2b byte0 miso", {24'd0, mi}, 32'h55);
        wait_rx(n + 1, "b2b first rx_valid");
        load(8'hAA, 1'b0);
        rx_exp_q.push_back(8'h02);
        xfer(8'h02, 8, mi);
        chk("b2b byte1 miso", {24'd0, mi}, 32'hAA);
        ss_high();
        wait_rx(n + 2, "b2b rx count");

        // load while not ready is dropped
        load(8'h3C, 1'b0);
        load(8'h99, 1'b0);
        frame(8'h42, 8'h3C, "held load");
        frame(8'h43, 8'h00, "ignored load");

        // partial byte discarded
        n = rx_cnt;
        ss_low();
        xfer(8'hF0, 5, mi);
        ss_high();
        repeat (20) @(posedge clk);
        #1 chk("partial no rx_valid", rx_cnt, n);
        chk("partial rx_data kept", {24'd0, rx_data}, 32'h43);
        frame(8'hC3, 8'h00, "after partial");
        chk("rx_data after partial", {24'd0, rx_data}, 32'hC3);

        // ss rise coincident with the 8th sclk fall
        n = rx_cnt;
        ss_low();
        rx_exp_q.push_back(8'h3A);
        xfer(8'h3A, 7, mi);
        @(posedge clk); #1 mosi = 1'b0; sclk = 1'b1;
        repeat (HALF) @(posedge clk);
        #1 sclk = 1'b0; ss = 1'b1;
        wait_rx(n + 1, "coincident ss rise rx");
        repeat (HALF) @(posedge clk);
        #1 chk("coincident busy", {31'd0, busy}, 32'd0);

        // reset mid-frame
        load(8'hFF, 1'b0);
        ss_low();
        xfer(8'h00, 4, mi);
        @(posedge clk); #1 sclk = 1'b1;
        repeat (HALF) @(posedge clk);
        load(8'h77, 1'b0);
        chk("miso before reset", {31'd0, miso}, 32'd1);
        #2 reset = 1'b1; sclk = 1'b0; ss = 1'b1; mosi = 1'b0;
        #1 chk("mid reset miso", {31'd0, miso}, 32'd0);
        chk("mid reset busy", {31'd0, busy}, 32'd0);
        chk("mid reset tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("mid reset rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("mid reset rx_data", {24'd0, rx_data}, 32'd0);
        chk("mid reset rx_overrun", {31'd0, rx_overrun}, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        frame(8'h6D, 8'h00, "after reset");
        chk("rx_overrun one byte after reset", {31'd0, rx_overrun}, 32'd0);
        chk("scoreboard drained", rx_exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
